// File: rtl/sa_autosa_ssa_xreq_arb.sv
// Round-robin arbiter sharing one 4-phase level handshake crossing among NREQ requesters.
// Launches one payload at a time, reports per-requester completion, flags stalled phases.
module sa_autosa_ssa_xreq_arb #(
  parameter int NREQ   = 4,
  parameter int DW     = 32,
  parameter int TOW    = 16,
  parameter int TO_CYC = 1024
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [NREQ-1:0]    req_i,
  input  logic [NREQ*DW-1:0] data_i,
  output logic [NREQ-1:0]    done_o,
  output logic               xreq_o,
  output logic [DW-1:0]      xdata_o,
  input  logic               xack_i,
  output logic               busy_o,
  output logic               timeout_o,
  input  logic               clr_i
);

  localparam int             IW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [TOW-1:0] TO_V = TOW'(TO_CYC);
  localparam logic [IW-1:0]  LAST = IW'(NREQ - 1);

  typedef enum logic [1:0] {S_IDLE, S_ASSERT, S_RELEASE, S_DONE} state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   gnt_q, gnt_d;
  logic            xreq_q, xreq_d;
  logic [DW-1:0]   xdata_q, xdata_d;
  logic [NREQ-1:0] done_q, done_d;
  logic            busy_q, busy_d;
  logic            tmo_q, tmo_d;
  logic [TOW-1:0]  cnt_q, cnt_d;
  logic            flg_q, flg_d;

  logic [TOW-1:0]  cnt_inc;
  logic            tmo_set;
  logic            win_vld;
  logic [IW-1:0]   win_idx;

  function automatic logic [TOW-1:0] sat_inc(input logic [TOW-1:0] v);
    return (&v) ? v : v + TOW'(1);
  endfunction

  // Descending scan so the set bit closest to the pointer (wrapping upward) wins.
  always_comb begin
    win_vld = 1'b0;
    win_idx = ptr_q;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_i[IW'((int'(ptr_q) + i) % NREQ)]) begin
        win_vld = 1'b1;
        win_idx = IW'((int'(ptr_q) + i) % NREQ);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    xreq_d  = xreq_q;
    xdata_d = xdata_q;
    done_d  = '0;
    cnt_d   = cnt_q;
    flg_d   = flg_q;
    tmo_set = 1'b0;
    cnt_inc = sat_inc(cnt_q);

    unique case (state_q)
      S_IDLE: begin
        if (win_vld && !xack_i) begin
          state_d = S_ASSERT;
          gnt_d   = win_idx;
          xdata_d = data_i[win_idx*DW +: DW];
          xreq_d  = 1'b1;
          cnt_d   = '0;
          flg_d   = 1'b0;
        end
      end
      S_ASSERT: begin
        if (xack_i) begin
          state_d = S_RELEASE;
          xreq_d  = 1'b0;
          cnt_d   = '0;
          flg_d   = 1'b0;
        end
      end
      S_RELEASE: begin
        if (!xack_i) begin
          state_d        = S_DONE;
          done_d[gnt_q]  = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        ptr_d   = (gnt_q == LAST) ? '0 : gnt_q + IW'(1);
      end
      default: state_d = S_IDLE;
    endcase

    // A phase that keeps waiting counts up; the flag fires once per phase.
    if ((state_q == S_ASSERT || state_q == S_RELEASE) && state_d == state_q) begin
      cnt_d   = cnt_inc;
      tmo_set = (TO_CYC != 0) && !flg_q && (cnt_inc == TO_V);
      flg_d   = flg_q | tmo_set;
    end

    tmo_d = tmo_q;
    if (clr_i)   tmo_d = 1'b0;
    if (tmo_set) tmo_d = 1'b1;

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      xreq_q  <= 1'b0;
      xdata_q <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
      tmo_q   <= 1'b0;
      cnt_q   <= '0;
      flg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      xreq_q  <= xreq_d;
      xdata_q <= xdata_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      tmo_q   <= tmo_d;
      cnt_q   <= cnt_d;
      flg_q   <= flg_d;
    end
  end

  assign done_o    = done_q;
  assign xreq_o    = xreq_q;
  assign xdata_o   = xdata_q;
  assign busy_o    = busy_q;
  assign timeout_o = tmo_q;

  a_to_cyc_fits: assert property (@(posedge i_clk)
    (TO_CYC >= 0) && (longint'(TO_CYC) < (longint'(1) << TOW)));

endmodule

// File: tb/tb_sa_autosa_ssa_xreq_arb.sv
// Bench for sa_autosa_ssa_xreq_arb: scoreboard of expected completions plus a far-side ack model.
module tb_sa_autosa_ssa_xreq_arb;

  localparam int NREQ   = 4;
  localparam int DW     = 32;
  localparam int TOW    = 16;
  localparam int TO_CYC = 8;

  logic               i_clk;
  logic               i_rst;
  logic [NREQ-1:0]    req_i;
  logic [NREQ*DW-1:0] data_i;
  logic [NREQ-1:0]    done_o;
  logic               xreq_o;
  logic [DW-1:0]      xdata_o;
  logic               xack_i;
  logic               busy_o;
  logic               timeout_o;
  logic               clr_i;

  typedef struct {
    int            idx;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          exp_q[$];
  int            n_tests = 0;
  int            n_fail  = 0;
  int            n_done  = 0;
  bit            dst_en  = 0;
  bit            hold_req = 0;
  bit            toggle_data = 0;
  int            ack_dly = 3;
  int            dcnt    = 0;
  logic [DW-1:0] stab_val;

  sa_autosa_ssa_xreq_arb #(
    .NREQ(NREQ), .DW(DW), .TOW(TOW), .TO_CYC(TO_CYC)
  ) dut (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .req_i    (req_i),
    .data_i   (data_i),
    .done_o   (done_o),
    .xreq_o   (xreq_o),
    .xdata_o  (xdata_o),
    .xack_i   (xack_i),
    .busy_o   (busy_o),
    .timeout_o(timeout_o),
    .clr_i    (clr_i)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] pay(input int k);
    return 32'hA5A5_0000 | DW'(k);
  endfunction

  task automatic set_base_data();
    for (int k = 0; k < NREQ; k++) data_i[k*DW +: DW] = pay(k);
  endtask

  task automatic push_exp(input int k);
    exp_t e;
    e.idx  = k;
    e.data = data_i[k*DW +: DW];
    exp_q.push_back(e);
  endtask

  // One clock: sample just after the edge, score completions, then step the far side.
  task automatic tick();
    exp_t e;
    @(posedge i_clk);
    #1;
    if (toggle_data && busy_o) begin
      check("xdata_stable", xdata_o, stab_val);
      for (int k = 0; k < NREQ; k++) data_i[k*DW +: DW] = DW'($urandom);
    end
    if (done_o != '0) begin
      n_done++;
      if (exp_q.size() == 0) begin
        check("done_unexpected", done_o, 0);
      end else begin
        e = exp_q.pop_front();
        check("done_onehot", done_o, 64'(1) << e.idx);
        check("done_xdata", xdata_o, e.data);
      end
      if (hold_req) begin
        if (exp_q.size() == 0) req_i = '0;
      end else begin
        req_i = req_i & ~done_o;
      end
    end
    if (dst_en) begin
      if (xreq_o && !xack_i) begin
        if (dcnt + 1 >= ack_dly) begin xack_i = 1'b1; dcnt = 0; end
        else dcnt++;
      end else if (!xreq_o && xack_i) begin
        if (dcnt + 1 >= ack_dly) begin xack_i = 1'b0; dcnt = 0; end
        else dcnt++;
      end else begin
        dcnt = 0;
      end
    end
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) tick();
    check("wait_drain", exp_q.size(), 0);
  endtask

  initial begin
    int n0;
    bit found;
    i_rst  = 1'b1;
    req_i  = '0;
    clr_i  = 1'b0;
    xack_i = 1'b0;
    set_base_data();
    repeat (2) @(posedge i_clk);
    #1;
    check("rst_xreq", xreq_o, 0);
    check("rst_xdata", xdata_o, 0);
    check("rst_done", done_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_tmo", timeout_o, 0);
    i_rst = 1'b0;
    tick();

    // Single request from requester 2
    dst_en = 1; ack_dly = 3;
    req_i = 4'b0100;
    push_exp(2);
    tick();
    check("t1_xreq_c1", xreq_o, 1);
    check("t1_xdata", xdata_o, 32'hA5A5_0002);
    check("t1_busy", busy_o, 1);
    n0 = n_done;
    wait_done(60);
    repeat (3) tick();
    check("t1_done_count", n_done - n0, 1);
    check("t1_busy_idle", busy_o, 0);
    check("t1_done_low", done_o, 0);

    // Asynchronous reset while in RELEASE
    req_i = 4'b0001;
    push_exp(0);
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (busy_o && !xreq_o && done_o == '0) found = 1;
    end
    check("t5_in_release", found, 1);
    #3;
    i_rst = 1'b1;
    xack_i = 1'b0; dcnt = 0; req_i = '0;
    exp_q.delete();
    #1;
    check("t5_rst_busy", busy_o, 0);
    check("t5_rst_xdata", xdata_o, 0);
    check("t5_rst_xreq", xreq_o, 0);
    check("t5_rst_done", done_o, 0);
    @(posedge i_clk);
    #2;
    i_rst = 1'b0;
    tick();

    // Fairness with all requesters held; pointer restarts at 0 after reset
    hold_req = 1;
    req_i = 4'b1111;
    push_exp(0); push_exp(1); push_exp(2); push_exp(3); push_exp(0);
    wait_done(200);
    hold_req = 0;
    repeat (3) tick();
    check("t2_busy_end", busy_o, 0);

    // Stale acknowledge blocks the launch
    dst_en = 0;
    xack_i = 1'b1;
    req_i = 4'b0001;
    push_exp(0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t3_stale_hold", xreq_o, 0);
    end
    xack_i = 1'b0;
    tick();
    check("t3_launch", xreq_o, 1);
    dcnt = 0; dst_en = 1;
    wait_done(60);
    repeat (2) tick();

    // Timeout with a silent far side
    dst_en = 0;
    xack_i = 1'b0;
    req_i = 4'b0010;
    push_exp(1);
    tick();
    check("t4_xreq", xreq_o, 1);
    repeat (7) tick();
    check("t4_tmo_pre", timeout_o, 0);
    tick();
    check("t4_tmo_set", timeout_o, 1);
    check("t4_xreq_held", xreq_o, 1);
    clr_i = 1'b1;
    tick();
    clr_i = 1'b0;
    check("t4_tmo_clr", timeout_o, 0);
    repeat (20) tick();
    check("t4_no_reflag", timeout_o, 0);
    check("t4_still_assert", xreq_o, 1);
    xack_i = 1'b1; dcnt = 0; dst_en = 1;
    wait_done(60);
    repeat (2) tick();
    check("t4_tmo_after", timeout_o, 0);

    // Payload stability while data_i churns
    req_i = 4'b1000;
    push_exp(3);
    stab_val = data_i[3*DW +: DW];
    tick();
    check("t6_launch_xdata", xdata_o, stab_val);
    toggle_data = 1;
    wait_done(60);
    toggle_data = 0;
    set_base_data();
    repeat (2) tick();
    check("t6_busy_end", busy_o, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sa_autosa_ssa_xreq_arb.md
Name: sa_autosa_ssa_xreq_arb

Overview:
- Source-domain controller that shares one 4-phase level handshake crossing among NREQ requesters.
- Round-robin arbitrates requesters, latches the winner's payload and drives a stable request level plus data toward the destination domain.
- Drives the 3-flop strict synchronizer cells (sa_autosa_ssa_sync3d). xack_i arrives already synchronized into i_clk.
- Reports completion per requester, and flags a sticky timeout when the far side stalls.

Parameters:
- NREQ, 4, number of requesters (2..16).
- DW, 32, payload width per requester.
- TOW, 16, timeout counter width.
- TO_CYC, 1024, cycles allowed per handshake phase before timeout is flagged; 0 disables the timeout.

Ports:
- i_clk  input  1  clock.
- i_rst  input  1  reset, asynchronous, active-high.
- req_i  input  NREQ  per-requester request level; held until that requester's done_o.
- data_i  input  NREQ*DW  payloads; requester k owns bits [k*DW +: DW].
- done_o  output  NREQ  one-hot, one-cycle completion pulse.
- xreq_o  output  1  crossing request level, feeds sync3d toward the destination.
- xdata_o  output  DW  held payload; stable whenever xreq_o=1.
- xack_i  input  1  destination acknowledge, already synchronized to i_clk.
- busy_o  output  1  high in any state other than IDLE.
- timeout_o  output  1  sticky timeout flag.
- clr_i  input  1  clears timeout_o.

Behaviour:
- Reset, asynchronous, applied at any time:
  - State = IDLE, xreq_o=0, xdata_o=0, done_o=0, busy_o=0, timeout_o=0.
  - Round-robin pointer = 0, grant index = 0, timeout counter = 0.
  - A transaction in flight is abandoned. The destination must be reset in the same reset domain.
- All outputs are registered.
- FSM states: IDLE, ASSERT, RELEASE, DONE.
- IDLE:
  - Launches when any req_i bit is set and xack_i=0.
  - The winner is the first set bit at or after the pointer, searching upward with wrap-around.
  - The same cycle latches the grant index and data_i slice into xdata_o, and sets xreq_o=1 next cycle; state becomes ASSERT.
  - If xack_i=1 (stale acknowledge), no launch until xack_i returns to 0.
- ASSERT: xreq_o=1. When xack_i=1 is sampled, the next cycle has xreq_o=0 and state RELEASE.
- RELEASE: xreq_o=0. When xack_i=0 is sampled, the next cycle raises done_o[grant]=1 for exactly one cycle and enters DONE.
- DONE:
  - Pointer becomes (grant+1) mod NREQ.
  - The next cycle returns to IDLE; arbitration resumes there.
- Latency:
  - req_i sampled in IDLE at cycle 0 gives xreq_o=1 at cycle 1.
  - xack_i rise sampled at cycle k gives xreq_o=0 at k+1.
  - xack_i fall sampled at cycle m gives done_o at m+1.
  - Minimum back-to-back spacing of xreq_o rises is 4 cycles plus the far-side round trip.
- xdata_o changes only on an IDLE launch. It holds its value through ASSERT, RELEASE, DONE and a following IDLE.
- Requester drops req_i mid-transaction: ignored; the transaction completes and done_o still pulses.
- req_i still high after done_o is treated as a new request. Round robin guarantees the other requesters are served first.
- data_i changes after launch have no effect.
- Timeout:
  - The counter clears on entry to ASSERT and on entry to RELEASE, increments each cycle in those states, and saturates at all-ones.
  - When the counter equals TO_CYC (TO_CYC≠0), timeout_o sets.
  - The FSM keeps waiting; 4-phase is never aborted.
  - clr_i clears timeout_o. If clr_i and a set condition occur in the same cycle, set wins.
  - The timeout is not re-flagged within the same phase after a clear.
- TO_CYC must fit in TOW bits. TO_CYC > 2^TOW−1 is illegal; the implementation asserts on it in simulation.

Test Plan:
- Single request: req_i=4'b0100, data slice 2=0xA5A5_0002; destination raises xack 3 cycles after xreq_o and drops it 3 cycles after xreq_o falls. Required: xreq_o=1 at cycle 1, xdata_o=0xA5A5_0002, done_o=4'b0100 exactly once, busy_o low after DONE.
- Fairness: req_i=4'b1111 held continuously with a responsive destination. Required: grant order 0,1,2,3,0 from done_o, and no requester is served twice before all others are served.
- Stale ack: xack_i=1 in IDLE with req_i=4'b0001. Required: xreq_o stays 0 until 1 cycle after xack_i falls.
- Timeout: TO_CYC=8, destination never acknowledges. Required: timeout_o=1 after 8 cycles in ASSERT, xreq_o held at 1. clr_i pulse → timeout_o=0, and it does not re-flag in the same phase. A late xack_i then completes normally.
- Reset mid-transaction: assert i_rst asynchronously while in RELEASE. Required: outputs reach reset values immediately without a clock edge; after release, arbitration restarts from pointer 0.
- Payload stability: toggle data_i every cycle during ASSERT and RELEASE. Required: xdata_o is constant from launch through DONE.
